// File: rtl/exec_writeback_stage.sv
// Writeback stage: registers ALU results onto the register-file write port,
// owns the architectural flags and HI, and splits 64-bit multiplies into two writes.
module exec_writeback_stage #(
  parameter int REG_ADDR_W = 5,
  parameter int DATA_W     = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [5:0]            opcode,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic [DATA_W-1:0]     alu_high,
  input  logic                  alu_carry,
  input  logic                  alu_zero,
  input  logic                  alu_sign,
  input  logic                  alu_ovf,
  input  logic [2:0]            br_cond,
  output logic                  wr_en,
  output logic [REG_ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0]     wr_data,
  output logic [3:0]            flags_q,
  output logic [DATA_W-1:0]     hi_q,
  output logic                  br_taken
);

  typedef enum logic [1:0] {IDLE, WB, WB_LO, WB_HI} state_t;
  typedef enum logic [1:0] {CLS_ALU, CLS_MUL, CLS_PASS, CLS_OTHER} cls_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_req_t;

  state_t  state;
  cls_t    cls;
  wb_req_t hold;
  logic    accept;

  assign in_ready = (state != WB_LO);
  assign accept   = in_valid && in_ready;

  always_comb begin
    cls = CLS_OTHER;
    if (opcode == 6'd0 || (opcode >= 6'd3 && opcode <= 6'd13)) cls = CLS_ALU;
    else if (opcode == 6'd1 || opcode == 6'd2)                 cls = CLS_MUL;
    else if (opcode == 6'd16 || opcode == 6'd32)               cls = CLS_PASS;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      flags_q <= 4'b0100;
      hi_q    <= '0;
      hold    <= '0;
    end else begin
      wr_en <= 1'b0;
      if (state == WB_LO) begin
        // Second half of a multiply: the write port is owned by the high word.
        state   <= WB_HI;
        wr_en   <= 1'b1;
        wr_addr <= hold.addr;
        wr_data <= hold.data;
      end else if (accept) begin
        case (cls)
          CLS_ALU: begin
            state   <= WB;
            wr_en   <= 1'b1;
            wr_addr <= rd;
            wr_data <= alu_result;
            flags_q <= {alu_carry, alu_zero, alu_sign, alu_ovf};
          end
          CLS_MUL: begin
            state     <= WB_LO;
            wr_en     <= 1'b1;
            wr_addr   <= rd;
            wr_data   <= alu_result;
            flags_q   <= {alu_carry, alu_zero, alu_sign, alu_ovf};
            hi_q      <= alu_high;
            hold.addr <= rd + REG_ADDR_W'(1);
            hold.data <= alu_high;
          end
          default: state <= IDLE;
        endcase
      end else begin
        state <= IDLE;
      end
    end
  end

  always_comb begin
    br_taken = 1'b0;
    case (br_cond)
      3'd0: br_taken = 1'b0;
      3'd1: br_taken = 1'b1;
      3'd2: br_taken = flags_q[2];
      3'd3: br_taken = !flags_q[2];
      3'd4: br_taken = flags_q[3];
      3'd5: br_taken = !flags_q[3];
      3'd6: br_taken = flags_q[1];
      3'd7: br_taken = flags_q[0];
      default: br_taken = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_exec_writeback_stage.sv
// Scoreboarded bench for exec_writeback_stage: expected writes queued at drive time,
// popped and compared whenever the stage strobes wr_en.
module tb_exec_writeback_stage;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [5:0]    opcode;
  logic [AW-1:0] rd;
  logic [DW-1:0] alu_result, alu_high;
  logic          alu_carry, alu_zero, alu_sign, alu_ovf;
  logic [2:0]    br_cond;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [3:0]    flags_q;
  logic [DW-1:0] hi_q;
  logic          br_taken;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } exp_wr_t;

  exp_wr_t sb[$];
  int vectors    = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  exec_writeback_stage #(.REG_ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .rd(rd), .alu_result(alu_result), .alu_high(alu_high),
    .alu_carry(alu_carry), .alu_zero(alu_zero), .alu_sign(alu_sign), .alu_ovf(alu_ovf),
    .br_cond(br_cond), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .flags_q(flags_q), .hi_q(hi_q), .br_taken(br_taken)
  );

  // Write-port monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && wr_en) begin
      vectors++;
      if (sb.size() == 0) begin
        miscompares++;
        $display("FAIL wr_unexpected: got addr=%0d data=%h, none expected", wr_addr, wr_data);
      end else begin
        exp_wr_t e;
        e = sb.pop_front();
        if (wr_addr !== e.addr || wr_data !== e.data) begin
          miscompares++;
          $display("FAIL wr_port: got addr=%0d data=%h, want addr=%0d data=%h",
                   wr_addr, wr_data, e.addr, e.data);
        end
      end
    end
  end

  task automatic drive(input logic v, input logic [5:0] op, input logic [AW-1:0] r,
                       input logic [DW-1:0] res, input logic [DW-1:0] hi, input logic [3:0] f);
    in_valid = v; opcode = op; rd = r; alu_result = res; alu_high = hi;
    {alu_carry, alu_zero, alu_sign, alu_ovf} = f;
  endtask

  task automatic cycle();
    @(posedge clk); @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; br_cond = 3'd2;
    drive(1'b0, 6'd0, '0, '0, '0, 4'b0);
    #12;
    vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("FAIL reset_wr_en: got %b want 0", wr_en); end
    vectors++; if (flags_q !== 4'b0100) begin miscompares++; $display("FAIL reset_flags: got %b want 0100", flags_q); end
    vectors++; if (hi_q !== 32'h0) begin miscompares++; $display("FAIL reset_hi: got %h want 0", hi_q); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    vectors++; if (br_taken !== 1'b1) begin miscompares++; $display("FAIL reset_br_z: got %b want 1", br_taken); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_add();
    drive(1'b1, 6'd0, 5'd5, 32'h0000_000A, '0, 4'b0000);
    sb.push_back('{addr: 5'd5, data: 32'h0000_000A});
    cycle();
    in_valid = 1'b0; br_cond = 3'd3;
    #1;
    vectors++; if (flags_q !== 4'b0000) begin miscompares++; $display("FAIL add_flags: got %b want 0000", flags_q); end
    vectors++; if (br_taken !== 1'b1) begin miscompares++; $display("FAIL add_br_nz: got %b want 1", br_taken); end
    @(negedge clk);
  endtask

  task automatic test_mul_wrap();
    drive(1'b1, 6'd1, 5'd31, 32'h1, 32'hDEAD_BEEF, 4'b0000);
    sb.push_back('{addr: 5'd31, data: 32'h1});
    sb.push_back('{addr: 5'd0,  data: 32'hDEAD_BEEF});
    cycle();
    // Cycle N+1: low word on the port, follow-on op held valid and stalled.
    drive(1'b1, 6'd6, 5'd2, 32'h0000_0022, 32'h0, 4'b0100);
    sb.push_back('{addr: 5'd2, data: 32'h0000_0022});
    vectors++; if (in_ready !== 1'b0) begin miscompares++; $display("FAIL mul_stall: in_ready got %b want 0", in_ready); end
    cycle();
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL mul_hi_ready: in_ready got %b want 1", in_ready); end
    vectors++; if (hi_q !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL mul_hi_q: got %h want deadbeef", hi_q); end
    cycle();
    in_valid = 1'b0;
    vectors++; if (flags_q !== 4'b0100) begin miscompares++; $display("FAIL mul_follow_flags: got %b want 0100", flags_q); end
    @(negedge clk);
  endtask

  task automatic test_pass_illegal();
    logic [5:0] ops [2];
    ops[0] = 6'd16; ops[1] = 6'd20;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, ops[i], 5'd9, 32'hBAD0_0000 + i, 32'hFFFF_FFFF, 4'b1011);
      cycle();
      in_valid = 1'b0;
      vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("FAIL pass_wr_en op%0d: got %b want 0", ops[i], wr_en); end
      vectors++; if (flags_q !== 4'b0100) begin miscompares++; $display("FAIL pass_flags op%0d: got %b want 0100", ops[i], flags_q); end
      vectors++; if (hi_q !== 32'hDEAD_BEEF) begin miscompares++; $display("FAIL pass_hi op%0d: got %h want deadbeef", ops[i], hi_q); end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_mul();
    drive(1'b1, 6'd2, 5'd7, 32'h0000_0077, 32'h0000_1234, 4'b0010);
    sb.push_back('{addr: 5'd7, data: 32'h0000_0077});
    cycle();
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (wr_en !== 1'b0) begin miscompares++; $display("FAIL midrst_wr_en: got %b want 0", wr_en); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_ready: got %b want 1", in_ready); end
    vectors++; if (hi_q !== 32'h0) begin miscompares++; $display("FAIL midrst_hi: got %h want 0", hi_q); end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL midrst_after_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_branch();
    logic exp_br [8];
    exp_br = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    drive(1'b1, 6'd4, 5'd9, 32'h0000_0055, '0, 4'b1010);
    sb.push_back('{addr: 5'd9, data: 32'h0000_0055});
    cycle();
    in_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      br_cond = 3'(c);
      #1;
      vectors++;
      if (br_taken !== exp_br[c]) begin
        miscompares++;
        $display("FAIL branch_cond%0d: got %b want %b", c, br_taken, exp_br[c]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      logic [AW-1:0] r;
      logic [DW-1:0] d;
      r = AW'($urandom_range(0, 31));
      d = $urandom;
      drive(1'b1, 6'(3 + i), r, d, '0, 4'(i));
      sb.push_back('{addr: r, data: d});
      vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready%0d: got %b want 1", i, in_ready); end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    @(negedge clk);
    vectors++; if (flags_q !== 4'd5) begin miscompares++; $display("FAIL b2b_flags: got %b want 0101", flags_q); end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_add();
    test_mul_wrap();
    test_pass_illegal();
    test_reset_mid_mul();
    test_branch();
    test_back_to_back();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain: %0d writes outstanding, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/exec_writeback_stage.md
Name: exec_writeback_stage

Overview:
- Sits directly downstream of the ALU and consumes its result, high word and four flags.
- Registers ALU outputs into the register-file write port.
- Owns the architectural flag register (C, Z, S, V) and the HI register.
- Evaluates branch conditions from the registered flags.
- A 64-bit multiply result takes two write cycles through the single write port. During the first of those cycles the stage stalls upstream.

Parameters:
- REG_ADDR_W, 5, register-file address width.
- DATA_W, 32, datapath width.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream presents an ALU operation this cycle.
- in_ready  output  1  stage accepts the operation this cycle.
- opcode  input  6  ALU opcode of the presented operation.
- rd  input  REG_ADDR_W  destination register.
- alu_result  input  DATA_W  ALU low result.
- alu_high  input  DATA_W  ALU high result (multiply only).
- alu_carry  input  1  ALU carry flag.
- alu_zero  input  1  ALU zero flag.
- alu_sign  input  1  ALU sign flag.
- alu_ovf  input  1  ALU overflow flag.
- br_cond  input  3  branch condition selector.
- wr_en  output  1  register-file write strobe.
- wr_addr  output  REG_ADDR_W  register-file write address.
- wr_data  output  DATA_W  register-file write data.
- flags_q  output  4  registered flags {C,Z,S,V}, C at bit 3.
- hi_q  output  DATA_W  HI register.
- br_taken  output  1  branch condition true.

Behaviour:
- Clock and reset: single clock. Asynchronous active-low reset (rst_n).
- Reset values:
  - state=IDLE.
  - wr_en=0, wr_addr=0, wr_data=0.
  - flags_q=4'b0100 (Z=1).
  - hi_q=0.
  - in_ready=1.
- Accept: an operation is accepted on a rising edge where in_valid && in_ready. in_ready = (state != WB_LO).
- Opcode classes (decoded at accept):
  - ALU class, opcodes 0, 3–13: write alu_result to rd and update all four flags.
  - Multiply class, opcodes 1 and 2: low word to rd, then high word to (rd+1) mod 32. Update all four flags and load hi_q <= alu_high.
  - Pass class, opcodes 16 and 32 (address calculation): no write, no flag update, no HI update.
  - Any other opcode: accepted and discarded. No write, no flag change.
- State machine:
  - States: IDLE, WB, WB_LO, WB_HI.
  - IDLE/WB/WB_HI, on accept of ALU class: next state WB.
  - IDLE/WB/WB_HI, on accept of multiply class: next state WB_LO. The high word and (rd+1) are latched into internal holding registers.
  - IDLE/WB/WB_HI, on accept of pass or other class: next state IDLE.
  - IDLE/WB/WB_HI, with no accept: next state IDLE.
  - WB_LO always goes to WB_HI. No accept is possible in WB_LO (in_ready=0).
- Output timing:
  - Outputs are registered. An accept at edge N drives wr_en=1, wr_addr=rd, wr_data=alu_result for cycle N+1 (one-cycle latency).
  - For multiply, cycle N+1 carries the low word. Cycle N+2 carries wr_en=1, wr_addr=(rd+1) mod 32, wr_data=high.
  - wr_en=0 in any cycle without a scheduled write.
- Back-to-back: an operation accepted in WB_HI writes in the cycle after WB_HI. Throughput is 1 op/cycle, except that each multiply inserts exactly one stall cycle.
- Flags and HI: flags_q and hi_q update at the accept edge and are visible from cycle N+1. There is no same-cycle bypass.
- Address wrap: rd=31 on a multiply writes the high word to register 0. Writes to register 0 are emitted; the register file owns the r0 policy.
- br_taken is combinational from flags_q. br_cond mapping:
  - 0: never.
  - 1: always.
  - 2: Z.
  - 3: !Z.
  - 4: C.
  - 5: !C.
  - 6: S.
  - 7: V.
- Reset mid-operation: asserting rst_n=0 during WB_LO or WB_HI aborts the pending high-word write. Outputs return to reset values immediately (asynchronously).
- in_valid while in_ready=0: the operation is not consumed. Upstream must hold it stable.

Test Plan:
- Reset → wr_en=0, flags_q=4'b0100, hi_q=0, in_ready=1. With br_cond=2, br_taken=1.
- Add result: accept opcode 0, rd=5, alu_result=32'h0000_000A, C=0 Z=0 S=0 V=0 → next cycle wr_en=1, wr_addr=5, wr_data=32'h0000_000A, flags_q=0. With br_cond=3, br_taken=1.
- Multiply stall and wrap:
  - Stimulus: accept opcode 1, rd=31, alu_result=32'h1, alu_high=32'hDEAD_BEEF, with a second op (opcode 6, rd=2) held valid.
  - Cycle N+1: wr 31←32'h1, in_ready=0.
  - Cycle N+2: wr 0←32'hDEAD_BEEF, in_ready=1, hi_q=32'hDEAD_BEEF.
  - Cycle N+3: wr 2← the held op's result.
- Pass and illegal opcodes: accept opcode 16, then opcode 20, each with flags C=1 Z=0 S=1 V=1 → wr_en stays 0 and flags_q is unchanged.
- Reset mid-multiply: assert rst_n low during WB_LO → wr_en=0 immediately. After release no high-word write occurs, and in_ready=1.
- Branch flags: accept op with C=1 S=1 Z=0 V=0, then sweep br_cond 0..7 → br_taken = 0,1,0,1,1,0,1,0.
